// File: rtl/fsmc_sram_resp.sv
// FSMC asynchronous SRAM/PSRAM target. Pins are registered once, phases are
// decoded from edges of that registered copy, data is served from an internal
// byte-lane RAM and the controller is stalled through FSMC_NWAIT.
module fsmc_sram_resp #(
    parameter int AW          = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int MUX_EN      = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          FSMC_NE,
    input  logic          FSMC_NOE,
    input  logic          FSMC_NWE,
    input  logic          FSMC_NL,
    input  logic [1:0]    FSMC_NBL,
    input  logic [AW-1:0] FSMC_A,
    input  logic [15:0]   FSMC_DO,
    output logic [15:0]   FSMC_DI,
    output logic          DI_OE,
    output logic          FSMC_NWAIT,
    output logic          ERR,
    output logic [15:0]   RD_CNT,
    output logic [15:0]   WR_CNT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Wait counter holds WAIT_CYCLES-1 down to 0
    localparam int WCW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RWAIT = 3'd2,
        WWAIT = 3'd3,
        RDATA = 3'd4,
        WDATA = 3'd5
    } state_t;

    // Registered pin copies and their previous values
    logic          ne_q;
    logic          noe_q;
    logic          nwe_q;
    logic          nl_q;
    logic [1:0]    nbl_q;
    logic [AW-1:0] a_q;
    logic [15:0]   do_q;
    logic          noe_p_q;
    logic          nwe_p_q;
    logic [1:0]    nbl_p_q;
    logic [15:0]   do_p_q;

    // Control state
    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             nwait_q, nwait_d;
    logic             di_oe_q, di_oe_d;
    logic             err_q, err_d;
    logic [15:0]      rd_cnt_q, rd_cnt_d;
    logic [15:0]      wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]    addr_q, addr_d;

    // Per-cycle strobes from the FSM
    logic             rd_inc;
    logic             wr_commit;
    logic             rd_load;

    // Edge and violation detection on the registered pins
    logic             noe_fall, noe_rise, nwe_fall, nwe_rise;
    logic             both_low_new;
    logic             addr_ld;
    logic [AW-1:0]    mux_addr;
    logic [AW-1:0]    addr_src;
    logic [DEPTH_LOG2-1:0] ram_idx;

    assign noe_fall = noe_p_q & ~noe_q;
    assign noe_rise = ~noe_p_q & noe_q;
    assign nwe_fall = nwe_p_q & ~nwe_q;
    assign nwe_rise = ~nwe_p_q & nwe_q;
    // Only the first cycle of NOE/NWE overlap counts, so ERR is a single pulse
    assign both_low_new = ~noe_q & ~nwe_q & (noe_p_q | nwe_p_q);

    // Multiplexed address: low 16 bits come from the data bus
    generate
        if (AW > 16) begin : g_mux_wide
            assign mux_addr = {a_q[AW-1:16], do_q};
        end else begin : g_mux_narrow
            assign mux_addr = do_q[AW-1:0];
        end
    endgenerate

    assign addr_src = (MUX_EN != 0) ? mux_addr : a_q;
    assign addr_ld  = (MUX_EN != 0) ? (~nl_q & ~ne_q)
                                    : (~ne_q & ((state_q == IDLE) || (state_q == ADDR)));
    assign ram_idx  = addr_q[DEPTH_LOG2-1:0];

    // Upper address bits are deliberately ignored so accesses wrap over the RAM
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q[AW-1:DEPTH_LOG2];

    // Pin input register stage plus one cycle of history for edge detection
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ne_q    <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            nl_q    <= 1'b1;
            nbl_q   <= 2'b11;
            a_q     <= '0;
            do_q    <= '0;
            noe_p_q <= 1'b1;
            nwe_p_q <= 1'b1;
            nbl_p_q <= 2'b11;
            do_p_q  <= '0;
        end else begin
            ne_q    <= FSMC_NE;
            noe_q   <= FSMC_NOE;
            nwe_q   <= FSMC_NWE;
            nl_q    <= FSMC_NL;
            nbl_q   <= FSMC_NBL;
            a_q     <= FSMC_A;
            do_q    <= FSMC_DO;
            noe_p_q <= noe_q;
            nwe_p_q <= nwe_q;
            nbl_p_q <= nbl_q;
            do_p_q  <= do_q;
        end
    end

    // Next-state, output and strobe logic of the phase decoder
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        nwait_d   = nwait_q;
        di_oe_d   = di_oe_q;
        err_d     = 1'b0;
        rd_inc    = 1'b0;
        wr_commit = 1'b0;
        rd_load   = 1'b0;

        case (state_q)
            IDLE: begin
                nwait_d = 1'b1;
                di_oe_d = 1'b0;
                if (!ne_q) begin
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (both_low_new) begin
                    err_d   = 1'b1;
                    di_oe_d = 1'b0;
                end else if (noe_fall && nwe_q) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RDATA;
                        di_oe_d = 1'b1;
                        rd_load = 1'b1;
                    end else begin
                        state_d = RWAIT;
                        nwait_d = 1'b0;
                        wcnt_d  = WCW'(WAIT_CYCLES - 1);
                    end
                end else if (nwe_fall && noe_q) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = WDATA;
                    end else begin
                        state_d = WWAIT;
                        nwait_d = 1'b0;
                        wcnt_d  = WCW'(WAIT_CYCLES - 1);
                    end
                end
            end

            RWAIT: begin
                if (both_low_new) begin
                    err_d   = 1'b1;
                    state_d = ADDR;
                    nwait_d = 1'b1;
                    di_oe_d = 1'b0;
                end else if (noe_rise) begin
                    // Controller abandoned the read before data was offered
                    state_d = ADDR;
                    nwait_d = 1'b1;
                end else if (wcnt_q == '0) begin
                    state_d = RDATA;
                    nwait_d = 1'b1;
                    di_oe_d = 1'b1;
                    rd_load = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end

            WWAIT: begin
                if (nwe_rise) begin
                    // Controller ignored NWAIT: keep the data, flag the error
                    wr_commit = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ADDR;
                    nwait_d   = 1'b1;
                end else if (wcnt_q == '0) begin
                    state_d = WDATA;
                    nwait_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end

            RDATA: begin
                rd_load = 1'b1;
                if (noe_rise) begin
                    di_oe_d = 1'b0;
                    rd_inc  = 1'b1;
                    state_d = ADDR;
                end
            end

            WDATA: begin
                if (both_low_new) begin
                    err_d   = 1'b1;
                    state_d = ADDR;
                    di_oe_d = 1'b0;
                end else if (nwe_rise) begin
                    wr_commit = 1'b1;
                    state_d   = ADDR;
                end
            end

            default: begin
                state_d = IDLE;
                nwait_d = 1'b1;
                di_oe_d = 1'b0;
            end
        endcase

        // Chip-select release aborts whatever phase is open
        if ((state_q != IDLE) && ne_q) begin
            state_d = IDLE;
            nwait_d = 1'b1;
            di_oe_d = 1'b0;
        end
    end

    // Saturating phase counters and address capture
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        addr_d   = addr_q;
        if (rd_inc && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (wr_commit && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (addr_ld) begin
            addr_d = addr_src;
        end
    end

    // Control state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            nwait_q  <= 1'b1;
            di_oe_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            nwait_q  <= nwait_d;
            di_oe_q  <= di_oe_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            addr_q   <= addr_d;
        end
    end

    // One RAM per byte lane so NBL maps directly onto lane write enables
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_q;

            // Lane write, using data/NBL from the last cycle NWE was low
            always_ff @(posedge HCLK) begin
                if (wr_commit && !nbl_p_q[gi]) begin
                    mem[ram_idx] <= do_p_q[gi*8 +: 8];
                end
            end

            // Registered lane read feeding FSMC_DI
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    rd_q <= '0;
                end else if (rd_load) begin
                    rd_q <= mem[ram_idx];
                end
            end

            assign FSMC_DI[gi*8 +: 8] = rd_q;
        end
    endgenerate

    assign DI_OE      = di_oe_q;
    assign FSMC_NWAIT = nwait_q;
    assign ERR        = err_q;
    assign RD_CNT     = rd_cnt_q;
    assign WR_CNT     = wr_cnt_q;

endmodule

// File: tb/tb_fsmc_sram_resp.sv
// Bench for fsmc_sram_resp: three responders (non-mux, mux, zero-wait) share
// one FSMC pin set; each transaction is checked against the targeted one.
module tb_fsmc_sram_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ne, noe, nwe, nl;
    logic [1:0]  nbl;
    logic [15:0] a, dout;

    logic [15:0] di   [3];
    logic [15:0] rdc  [3];
    logic [15:0] wrc  [3];
    logic        dioe [3];
    logic        nwait[3];
    logic        err  [3];

    always #5 clk = ~clk;

    fsmc_sram_resp #(.AW(16), .DEPTH_LOG2(8), .WAIT_CYCLES(2), .MUX_EN(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .FSMC_NE(ne), .FSMC_NOE(noe), .FSMC_NWE(nwe),
        .FSMC_NL(nl), .FSMC_NBL(nbl), .FSMC_A(a), .FSMC_DO(dout), .FSMC_DI(di[0]),
        .DI_OE(dioe[0]), .FSMC_NWAIT(nwait[0]), .ERR(err[0]), .RD_CNT(rdc[0]), .WR_CNT(wrc[0]));

    fsmc_sram_resp #(.AW(16), .DEPTH_LOG2(8), .WAIT_CYCLES(2), .MUX_EN(1)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .FSMC_NE(ne), .FSMC_NOE(noe), .FSMC_NWE(nwe),
        .FSMC_NL(nl), .FSMC_NBL(nbl), .FSMC_A(a), .FSMC_DO(dout), .FSMC_DI(di[1]),
        .DI_OE(dioe[1]), .FSMC_NWAIT(nwait[1]), .ERR(err[1]), .RD_CNT(rdc[1]), .WR_CNT(wrc[1]));

    fsmc_sram_resp #(.AW(16), .DEPTH_LOG2(8), .WAIT_CYCLES(0), .MUX_EN(0)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .FSMC_NE(ne), .FSMC_NOE(noe), .FSMC_NWE(nwe),
        .FSMC_NL(nl), .FSMC_NBL(nbl), .FSMC_A(a), .FSMC_DO(dout), .FSMC_DI(di[2]),
        .DI_OE(dioe[2]), .FSMC_NWAIT(nwait[2]), .ERR(err[2]), .RD_CNT(rdc[2]), .WR_CNT(wrc[2]));

    typedef struct {
        int          d;      // which responder is the target
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  nbl;
        logic [15:0] exp;    // expected read data
    } vec_t;

    vec_t        vecs[15];
    logic [15:0] sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // One complete address + read/write phase; returns NWAIT-low count and read latency
    task automatic access(input int d, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, input logic [1:0] nbl_v,
                          output int lows, output int lat);
        logic [15:0] req;
        lows = 0;
        lat  = -1;
        @(negedge clk);
        ne = 1'b0; nl = 1'b0; a = addr; dout = addr; nbl = nbl_v;
        @(negedge clk);
        @(negedge clk);
        nl = 1'b1; dout = wr ? data : 16'h0000;
        @(negedge clk);
        if (wr) begin
            nwe = 1'b0;
            for (int i = 1; i <= 6; i++) begin
                @(negedge clk);
                if (nwait[d] === 1'b0) lows++;
            end
            nwe = 1'b1;
        end else begin
            noe = 1'b0;
            for (int i = 1; i <= 12 && lat < 0; i++) begin
                @(negedge clk);
                if (nwait[d] === 1'b0) lows++;
                if (dioe[d] === 1'b1) lat = i;
            end
            req = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hXXXX;
            if (lat >= 0) begin
                check16($sformatf("rdata d%0d a%h", d, addr), di[d], req);
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL read_timeout d%0d a%h: actual no DI_OE required DI_OE within 12 cycles", d, addr);
            end
            @(negedge clk);
            noe = 1'b1;
        end
        repeat (3) @(negedge clk);
        ne = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        int lows, lat, wexp;
        for (int i = lo; i <= hi; i++) begin
            wexp = (vecs[i].d == 2) ? 0 : 2;
            if (!vecs[i].wr) sb_q.push_back(vecs[i].exp);
            access(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].nbl, lows, lat);
            if (vecs[i].wr) exp_wr++; else exp_rd++;
            $display("vec %0d d%0d %s a=%h d=%h nbl=%b lows=%0d lat=%0d", i, vecs[i].d,
                     vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].wr ? vecs[i].data : di[vecs[i].d],
                     vecs[i].nbl, lows, lat);
            check16($sformatf("nwait_low_cycles v%0d", i), 16'(lows), 16'(wexp));
            if (!vecs[i].wr) check16($sformatf("read_latency v%0d", i), 16'(lat), 16'(wexp + 2));
            check16($sformatf("rd_cnt v%0d", i), rdc[vecs[i].d], 16'(exp_rd));
            check16($sformatf("wr_cnt v%0d", i), wrc[vecs[i].d], 16'(exp_wr));
        end
    endtask

    initial begin
        int ecount;
        bit oe_seen;
        int lat;

        //           d  wr  addr      data      nbl    exp
        vecs[0]  = '{0, 1, 16'h0012, 16'hA5C3, 2'b00, 16'h0000};
        vecs[1]  = '{0, 0, 16'h0012, 16'h0000, 2'b00, 16'hA5C3};
        vecs[2]  = '{0, 1, 16'h0005, 16'hFFFF, 2'b00, 16'h0000};
        vecs[3]  = '{0, 1, 16'h0005, 16'h1234, 2'b10, 16'h0000};
        vecs[4]  = '{0, 0, 16'h0005, 16'h0000, 2'b00, 16'hFF34};
        vecs[5]  = '{0, 0, 16'h0112, 16'h0000, 2'b00, 16'hA5C3};
        vecs[6]  = '{0, 1, 16'h0012, 16'hABCD, 2'b01, 16'h0000};
        vecs[7]  = '{0, 0, 16'h0012, 16'h0000, 2'b00, 16'hABC3};
        vecs[8]  = '{1, 1, 16'h0107, 16'hBEEF, 2'b00, 16'h0000};
        vecs[9]  = '{1, 0, 16'h0107, 16'h0000, 2'b00, 16'hBEEF};
        vecs[10] = '{1, 0, 16'h0007, 16'h0000, 2'b00, 16'hBEEF};
        vecs[11] = '{2, 1, 16'h0033, 16'h5A5A, 2'b00, 16'h0000};
        vecs[12] = '{2, 0, 16'h0033, 16'h0000, 2'b00, 16'h5A5A};
        vecs[13] = '{2, 1, 16'h0033, 16'h00C3, 2'b10, 16'h0000};
        vecs[14] = '{2, 0, 16'h0033, 16'h0000, 2'b00, 16'h5AC3};

        ne = 1'b1; noe = 1'b1; nwe = 1'b1; nl = 1'b1; nbl = 2'b11; a = '0; dout = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check16($sformatf("reset di d%0d", d), di[d], 16'h0000);
            check16($sformatf("reset di_oe d%0d", d), {15'b0, dioe[d]}, 16'd0);
            check16($sformatf("reset nwait d%0d", d), {15'b0, nwait[d]}, 16'd1);
            check16($sformatf("reset err d%0d", d), {15'b0, err[d]}, 16'd0);
            check16($sformatf("reset rd_cnt d%0d", d), rdc[d], 16'd0);
            check16($sformatf("reset wr_cnt d%0d", d), wrc[d], 16'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Non-mux and mux vectors (all W=2 responders see every phase)
        run_vecs(0, 10);

        // NE released while the read is still in its wait phase
        @(negedge clk);
        ne = 1'b0; nl = 1'b0; a = 16'h0012; dout = 16'h0012;
        repeat (2) @(negedge clk);
        nl = 1'b1;
        @(negedge clk);
        noe = 1'b0;
        repeat (2) @(negedge clk);
        check16("ne_abort nwait_in_rwait", {15'b0, nwait[0]}, 16'd0);
        ne = 1'b1; noe = 1'b1;
        repeat (2) @(negedge clk);
        check16("ne_abort nwait_after_release", {15'b0, nwait[0]}, 16'd1);
        oe_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dioe[0] === 1'b1) oe_seen = 1'b1;
            @(negedge clk);
        end
        check16("ne_abort di_oe_seen", {15'b0, oe_seen}, 16'd0);
        check16("ne_abort rd_cnt", rdc[0], 16'(exp_rd));
        $display("ne_abort: nwait=%b di_oe_seen=%b rd_cnt=%0d", nwait[0], oe_seen, rdc[0]);

        // NOE and NWE asserted together in the address phase
        @(negedge clk);
        ne = 1'b0; nl = 1'b0; a = 16'h0012; dout = 16'h0012; nbl = 2'b00;
        repeat (2) @(negedge clk);
        nl = 1'b1; dout = 16'h0000;
        @(negedge clk);
        noe = 1'b0; nwe = 1'b0;
        ecount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (err[0] === 1'b1) ecount++;
        end
        noe = 1'b1; nwe = 1'b1;
        repeat (3) @(negedge clk);
        ne = 1'b1;
        repeat (3) @(negedge clk);
        check16("violation err_pulse_cycles", 16'(ecount), 16'd1);
        check16("violation wr_cnt", wrc[0], 16'(exp_wr));
        $display("violation: err_cycles=%0d wr_cnt=%0d", ecount, wrc[0]);
        begin
            int lows;
            sb_q.push_back(16'hABC3);
            access(0, 1'b0, 16'h0012, 16'h0000, 2'b00, lows, lat);
            exp_rd++;
            $display("violation readback: a=0012 d=%h", di[0]);
        end

        // Asynchronous reset while the read data is being driven
        @(negedge clk);
        ne = 1'b0; nl = 1'b0; a = 16'h0005; dout = 16'h0005; nbl = 2'b00;
        repeat (2) @(negedge clk);
        nl = 1'b1;
        @(negedge clk);
        noe = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12 && lat < 0; i++) begin
            @(negedge clk);
            if (dioe[0] === 1'b1) lat = i;
        end
        if (lat < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL reset_mid_read: actual no DI_OE required DI_OE before reset");
        end
        #2 rst_n = 1'b0;
        #1;
        check16("reset_mid di_oe", {15'b0, dioe[0]}, 16'd0);
        check16("reset_mid nwait", {15'b0, nwait[0]}, 16'd1);
        check16("reset_mid rd_cnt", rdc[0], 16'd0);
        check16("reset_mid wr_cnt", wrc[0], 16'd0);
        $display("reset_mid: di_oe=%b nwait=%b rd_cnt=%0d wr_cnt=%0d", dioe[0], nwait[0], rdc[0], wrc[0]);
        noe = 1'b1; ne = 1'b1; nbl = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        repeat (2) @(negedge clk);

        // Zero-wait responder after reset
        run_vecs(11, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: actual run still active required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
